// File: rtl/serial_msg_sequencer.sv
// Byte-buffer message sequencer: replays a stored message to a busy/start
// handshake transmitter, one-shot or continuously with an idle gap between repeats.
module serial_msg_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int GAP_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [7:0]       wr_data,
  input  logic [AW:0]      msg_len,
  input  logic [GAP_W-1:0] gap_cycles,
  input  logic             mode,
  input  logic             go,
  input  logic             abort,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             active,
  output logic             done,
  output logic [AW-1:0]    byte_idx
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  localparam logic [AW:0]      LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0]      LEN_ONE = (AW+1)'(1);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  state_t             state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [AW:0]        len_q, len_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               mode_q, mode_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               abort_q, abort_d;
  logic               done_q, done_d;

  logic               wr_accept;
  logic               last_byte;
  logic [AW:0]        len_clamped;
  logic [7:0]         mem_rd [DEPTH];

  function automatic logic [7:0] init_byte(input int idx);
    case (idx)
      0:       return 8'h40;
      1:       return 8'h30;
      2:       return 8'h2F;
      3:       return 8'h0A;
      default: return 8'h00;
    endcase
  endfunction

  assign wr_accept = wr_en && (state_q == ST_IDLE);

  // Buffer is deliberately outside the reset domain; contents survive rst.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    logic [7:0] byte_q = init_byte(gi);
    always_ff @(posedge clk) begin
      if (wr_accept && (wr_addr == AW'(gi))) begin
        byte_q <= wr_data;
      end
    end
    assign mem_rd[gi] = byte_q;
  end

  assign len_clamped = (msg_len > LEN_MAX) ? LEN_MAX : msg_len;
  assign last_byte   = ({1'b0, idx_q} == (len_q - LEN_ONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      mode_q    <= 1'b0;
      tx_data_q <= 8'h00;
      abort_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      mode_q    <= mode_d;
      tx_data_q <= tx_data_d;
      abort_q   <= abort_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    mode_d    = mode_q;
    tx_data_d = tx_data_q;
    abort_d   = abort_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (go && !abort) begin
          if (msg_len == '0) begin
            done_d = 1'b1;
          end else if (!tx_busy) begin
            state_d = ST_LOAD;
            idx_d   = '0;
            len_d   = len_clamped;
            gap_d   = gap_cycles;
            mode_d  = mode;
          end
        end
      end

      ST_LOAD: begin
        tx_data_d = mem_rd[idx_q];
        state_d   = abort ? ST_IDLE : ST_ISSUE;
      end

      ST_ISSUE: begin
        if (abort) abort_d = 1'b1;
        state_d = ST_WAIT_HI;
      end

      ST_WAIT_HI: begin
        if (abort) abort_d = 1'b1;
        if (tx_busy) state_d = ST_WAIT_LO;
      end

      ST_WAIT_LO: begin
        // A pending abort lets the byte on the wire finish, then beats any repeat.
        if (!tx_busy) begin
          if (abort_q || abort) begin
            state_d = ST_IDLE;
          end else if (!last_byte) begin
            idx_d   = idx_q + AW'(1);
            state_d = ST_LOAD;
          end else if (!mode_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = '0;
            if (gap_q == '0) begin
              state_d = ST_LOAD;
            end else begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_q;
            end
          end
        end else if (abort) begin
          abort_d = 1'b1;
        end
      end

      ST_GAP: begin
        if (abort) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
        end else if (gap_cnt_q == GAP_ONE) begin
          state_d   = ST_LOAD;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign tx_start = (state_q == ST_ISSUE);
  assign tx_data  = tx_data_q;
  assign active   = (state_q != ST_IDLE);
  assign done     = done_q;
  assign byte_idx = idx_q;

endmodule

// File: tb/tb_serial_msg_sequencer.sv
// Directed + randomized bench for serial_msg_sequencer with a behavioural
// transmitter and a reference buffer/message model.
module tb_serial_msg_sequencer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int GAP_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [7:0]       wr_data;
  logic [AW:0]      msg_len;
  logic [GAP_W-1:0] gap_cycles;
  logic             mode;
  logic             go;
  logic             abort;
  logic             tx_busy = 1'b0;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             active;
  logic             done;
  logic [AW-1:0]    byte_idx;

  always #5 clk = ~clk;

  serial_msg_sequencer #(.DEPTH(DEPTH), .AW(AW), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .gap_cycles(gap_cycles), .mode(mode), .go(go),
    .abort(abort), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .active(active), .done(done), .byte_idx(byte_idx)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int busy_hold = 10;
  int busy_left = 0;
  bit rise_pend = 1'b0;
  logic [7:0] ref_mem [DEPTH];
  logic [7:0] cap_data [$];
  int         cap_idx  [$];
  int         cap_cyc  [$];

  // Transmitter: busy rises one cycle after a start and stays high busy_hold cycles.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (done) done_cnt++;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) tx_busy = 1'b0;
    end
    if (rise_pend) begin
      rise_pend = 1'b0;
      tx_busy   = 1'b1;
      busy_left = busy_hold;
    end
    if (tx_start) begin
      cap_data.push_back(tx_data);
      cap_idx.push_back(int'(byte_idx));
      cap_cyc.push_back(cyc);
      rise_pend = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(int addr, logic [7:0] data);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
    tick();
    wr_en = 1'b0;
    ref_mem[addr] = data;
  endtask

  task automatic wait_done(int d0, int budget);
    while (done_cnt == d0 && budget > 0) begin
      tick();
      budget--;
    end
  endtask

  task automatic wait_idle(string tag, int budget);
    while (active && budget > 0) begin
      tick();
      budget--;
    end
    check({tag, "_idle"}, active, 1'b0);
  endtask

  // Expected stream: buffer bytes 0..len-1, repeated reps times.
  task automatic check_msg(string tag, int base, int len_eff, int reps);
    check({tag, "_count"}, cap_data.size() - base, len_eff * reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < len_eff; i++) begin
        int k = base + r * len_eff + i;
        if (k < cap_data.size()) begin
          check($sformatf("%s_data_%0d_%0d", tag, r, i), cap_data[k], ref_mem[i]);
          check($sformatf("%s_idx_%0d_%0d", tag, r, i), cap_idx[k], i);
        end
      end
    end
  endtask

  task automatic one_shot(string tag, int len_in, int hold, bit wr_same = 1'b0,
                          logic [7:0] wdata = 8'h00);
    int base    = cap_data.size();
    int d0      = done_cnt;
    int len_eff = (len_in > DEPTH) ? DEPTH : len_in;
    int go_cyc;
    busy_hold = hold;
    msg_len = (AW+1)'(len_in); mode = 1'b0; go = 1'b1;
    if (wr_same) begin
      wr_en = 1'b1; wr_addr = '0; wr_data = wdata;
      ref_mem[0] = wdata;
    end
    go_cyc = cyc;
    tick();
    go = 1'b0; wr_en = 1'b0;
    wait_done(d0, (len_eff + 2) * (hold + 6) + 20);
    tick(2);
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_active"}, active, 1'b0);
    check_msg(tag, base, len_eff, 1);
    if (cap_data.size() > base) check({tag, "_latency"}, cap_cyc[base] - go_cyc, 2);
    if (cap_data.size() > base + 1)
      check({tag, "_spacing"}, cap_cyc[base + 1] - cap_cyc[base], hold + 3);
  endtask

  initial begin
    int base;
    int d0;
    int budget;
    int len;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    ref_mem[0] = 8'h40; ref_mem[1] = 8'h30; ref_mem[2] = 8'h2F; ref_mem[3] = 8'h0A;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; msg_len = '0;
    gap_cycles = '0; mode = 1'b0; go = 1'b0; abort = 1'b0;
    tick(3);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_active", active, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_byte_idx", byte_idx, 0);
    rst = 1'b0;
    tick(2);

    one_shot("powerup", 4, 10);

    for (int t = 0; t < 3; t++) begin
      len = $urandom_range(1, DEPTH);
      for (int a = 0; a < len; a++) write_byte(a, 8'($urandom));
      one_shot($sformatf("rand%0d", t), len, $urandom_range(1, 4));
    end

    for (int a = 0; a < DEPTH; a++) write_byte(a, 8'($urandom));
    one_shot("clamp", DEPTH + 3, 1);
    one_shot("full", DEPTH, 2);

    // Continuous ABAB with gap 5; mid-run input changes must be ignored.
    write_byte(0, 8'h41);
    write_byte(1, 8'h42);
    busy_hold = 10;
    base = cap_data.size(); d0 = done_cnt;
    msg_len = 2; gap_cycles = 5; mode = 1'b1; go = 1'b1;
    tick();
    go = 1'b0; msg_len = 7; gap_cycles = 0; mode = 1'b0;
    budget = 200;
    while (cap_data.size() - base < 6 && budget > 0) begin tick(); budget--; end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle("cont", 60);
    check_msg("cont", base, 2, 3);
    check("cont_no_done", done_cnt - d0, 0);
    if (cap_data.size() > base + 2) begin
      check("cont_intra", cap_cyc[base + 1] - cap_cyc[base], 13);
      check("cont_gap", cap_cyc[base + 2] - cap_cyc[base + 1], 18);
    end

    // Abort while byte 1 is on the wire.
    busy_hold = 6;
    base = cap_data.size(); d0 = done_cnt;
    msg_len = 4; mode = 1'b0; go = 1'b1;
    tick();
    go = 1'b0;
    budget = 100;
    while (!(cap_data.size() - base >= 2 && tx_busy) && budget > 0) begin tick(); budget--; end
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_still_active", active, 1'b1);
    wait_idle("abort", 30);
    tick(30);
    check("abort_starts", cap_data.size() - base, 2);
    check("abort_no_done", done_cnt - d0, 0);
    if (cap_idx.size() > 0) check("abort_last_idx", cap_idx[cap_idx.size() - 1], 1);

    // Zero-length message.
    base = cap_data.size();
    msg_len = 0; go = 1'b1;
    tick();
    go = 1'b0;
    check("len0_done_pulse", done, 1'b1);
    tick();
    check("len0_done_low", done, 1'b0);
    tick(5);
    check("len0_no_start", cap_data.size() - base, 0);
    check("len0_active", active, 1'b0);

    // go and abort together in IDLE.
    base = cap_data.size(); d0 = done_cnt;
    msg_len = 3; go = 1'b1; abort = 1'b1;
    tick();
    go = 1'b0; abort = 1'b0;
    tick(5);
    check("goabort_active", active, 1'b0);
    check("goabort_no_start", cap_data.size() - base, 0);
    check("goabort_no_done", done_cnt - d0, 0);

    // Write while active is dropped.
    busy_hold = 3;
    base = cap_data.size(); d0 = done_cnt;
    msg_len = 2; mode = 1'b0; go = 1'b1;
    tick();
    go = 1'b0;
    tick(3);
    wr_en = 1'b1; wr_addr = '0; wr_data = 8'h99;
    tick();
    wr_en = 1'b0;
    wait_done(d0, 100);
    tick(2);
    check_msg("drop_run", base, 2, 1);
    one_shot("drop_old", 1, 2);
    one_shot("wr_go", 1, 2, 1'b1, 8'h5A);

    // Reset while waiting for busy to rise.
    busy_hold = 5;
    base = cap_data.size();
    msg_len = 3; mode = 1'b0; go = 1'b1;
    tick();
    go = 1'b0;
    budget = 20;
    while (cap_data.size() == base && budget > 0) begin tick(); budget--; end
    tick();
    rst = 1'b1;
    tick();
    check("midrst_tx_start", tx_start, 1'b0);
    check("midrst_tx_data", tx_data, 8'h00);
    check("midrst_active", active, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_byte_idx", byte_idx, 0);
    rst = 1'b0;
    tick(40);
    check("midrst_no_restart", cap_data.size() - base, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_msg_sequencer.md
SERIAL_MSG_SEQUENCER -- requirements
Module: serial_msg_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning message buffer depth in bytes (power of 2, 2..256).
REQ-002 SHALL have parameter AW, default 4, meaning buffer address width, equal to log2(DEPTH).
REQ-003 SHALL have parameter GAP_W, default 16, meaning width of the inter-message gap counter.
REQ-004 SHALL have the following ports:
  clk  in  1  single clock; all logic on rising edge.
  rst  in  1  synchronous active-high reset.
  wr_en  in  1  buffer write strobe.
  wr_addr  in  AW  buffer write address.
  wr_data  in  8  buffer write byte.
  msg_len  in  AW+1  bytes per message (0..DEPTH).
  gap_cycles  in  GAP_W  idle cycles between repeats in continuous mode.
  mode  in  1  0 = one-shot; 1 = continuous.
  go  in  1  start request, level-sampled in IDLE.
  abort  in  1  stop request.
  tx_busy  in  1  transmitter busy.
  tx_start  out  1  one-cycle transmit request.
  tx_data  out  8  byte to transmit; valid while tx_start = 1.
  active  out  1  high in any state except IDLE.
  done  out  1  one-cycle pulse on normal one-shot completion.
  byte_idx  out  AW  index of the byte currently issued.

Function
REQ-005 SHALL implement states IDLE, LOAD, ISSUE, WAIT_HI, WAIT_LO, GAP.
REQ-006 SHALL capture msg_len (clamped to DEPTH), gap_cycles and mode on leaving IDLE; changes to these inputs while active SHALL have no effect.
REQ-007 IDLE: go=1, tx_busy=0, msg_len≠0 -> LOAD at next edge, byte_idx=0; go while tx_busy=1 SHALL wait in IDLE.
REQ-008 IDLE: go=1 with msg_len=0 -> stay IDLE, with no tx_start and done pulsed for 1 cycle.
REQ-009 LOAD SHALL register mem[byte_idx] into tx_data and go to ISSUE (1 cycle).
REQ-010 ISSUE SHALL drive tx_start=1 for exactly 1 cycle and then go to WAIT_HI; tx_start is therefore high 2 cycles after go is sampled.
REQ-011 WAIT_HI SHALL hold until tx_busy=1, then go to WAIT_LO; WAIT_LO SHALL hold until tx_busy=0.
REQ-012 On tx_busy falling in WAIT_LO, if byte_idx < len-1, byte_idx SHALL increment and the FSM SHALL go to LOAD.
REQ-013 On the last byte in one-shot mode, the FSM SHALL go to IDLE with done=1 for that single following cycle.
REQ-014 On the last byte in continuous mode, the FSM SHALL go to GAP with byte_idx=0 and no done pulse.
REQ-015 GAP SHALL count exactly gap_cycles cycles and then go to LOAD; gap_cycles=0 SHALL go directly to LOAD.
REQ-016 abort SHALL be sampled in every non-IDLE state and SHALL behave as follows:
  in LOAD or GAP -> IDLE at the next edge;
  in ISSUE, WAIT_HI or WAIT_LO -> the current byte completes (tx_busy falls), then IDLE;
  no done pulse; abort has priority over repeat.
REQ-017 abort in IDLE SHALL be ignored; abort and go together in IDLE SHALL produce no start.
REQ-018 Writes SHALL be accepted only while active=0; writes while active=1 SHALL be dropped.
REQ-019 A write and go in the same IDLE cycle SHALL both take effect, and LOAD SHALL read the newly written data.
REQ-020 tx_data SHALL hold its value outside ISSUE until the next LOAD.
REQ-021 There SHALL be no combinational path from tx_busy to tx_start.

Reset
REQ-022 rst=1 at a clock edge SHALL force IDLE with tx_start=0, tx_data=0x00, active=0, done=0, byte_idx=0, and the gap counter cleared.
REQ-023 Buffer contents SHALL be unaffected by rst; power-up contents are mem[0..3] = 0x40, 0x30, 0x2F, 0x0A, with all other bytes 0x00.
REQ-024 rst mid-message SHALL abandon the message immediately, with no further tx_start.

Verification
REQ-025 Power-up one-shot: msg_len=4, mode=0, go pulse; the transmitter model raises busy 1 cycle after start and holds it 10 cycles -> tx_data sequence 0x40, 0x30, 0x2F, 0x0A, one tx_start per byte, and done once.
REQ-026 Continuous: write "AB" at 0..1, msg_len=2, gap=5, mode=1 -> ABAB... with exactly 5 cycles from GAP entry to LOAD, and done never asserted.
REQ-027 Abort in WAIT_LO of byte 1 -> byte 1 busy completes, no byte 2 start, IDLE, done=0.
REQ-028 Boundaries: msg_len=0 -> done pulse with no tx_start; msg_len=DEPTH+... clamp; msg_len=DEPTH -> byte_idx reaches DEPTH-1 and ends with no wrap.
REQ-029 Write to address 0 during an active message is dropped; the next message still sends the old byte; write+go in the same cycle sends the new byte.
REQ-030 rst asserted during WAIT_HI -> all outputs at reset values on the next cycle, and no tx_start until a new go.
